// File: rtl/tt_um_unload.sv
// Readback transmitter for the packed ternary weight array.
// On start it snapshots the weights and streams each row as an MSB beat and then an LSB beat.
module tt_um_unload #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ui_start,
    input  logic [6:0]                           ui_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
    input  logic                                 ui_ready,
    output logic [MAX_IN_LEN-1:0]                uo_data,
    output logic                                 uo_valid,
    output logic                                 uo_last,
    output logic                                 uo_busy,
    output logic                                 uo_done
);

    localparam int W_W   = 2 * MAX_IN_LEN * MAX_OUT_LEN;
    localparam int ROW_W = $clog2(MAX_OUT_LEN);

    // Handshake: a beat transfers on a rising edge where uo_valid && ui_ready.
    // uo_data and uo_last hold until that edge; a beat is never dropped or reordered.

    typedef enum logic [1:0] {
        S_IDLE,
        S_MSB,
        S_LSB
    } state_t;

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ROW_W-1:0]        last_row_q, last_row_d;
    logic [3:0]              last_col_q, last_col_d;
    logic [W_W-1:0]          snap_q, snap_d;
    logic [MAX_IN_LEN-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    xfer;

    // One plane (MSB or LSB) of a row; columns beyond last_col read as zero.
    function automatic logic [MAX_IN_LEN-1:0] beat_of(
        input logic [W_W-1:0]   w,
        input logic [ROW_W-1:0] r,
        input logic [3:0]       lc,
        input logic             msb
    );
        logic [MAX_IN_LEN-1:0] b;
        int                    idx;
        b = '0;
        for (int c = 0; c < MAX_IN_LEN; c++) begin
            idx = c * MAX_OUT_LEN + int'(r);
            if (c <= int'(lc)) begin
                b[c] = msb ? w[2*idx+1] : w[2*idx];
            end
        end
        return b;
    endfunction

    assign xfer = valid_q & ui_ready;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        snap_d     = snap_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = '0;
                if (ui_start) begin
                    snap_d     = ui_weights;
                    last_row_d = ROW_W'(ui_param[2:0]);
                    last_col_d = ui_param[6:3];
                    row_d      = '0;
                    state_d    = S_MSB;
                    valid_d    = 1'b1;
                    data_d     = beat_of(ui_weights, '0, ui_param[6:3], 1'b1);
                end
            end
            S_MSB: begin
                if (xfer) begin
                    state_d = S_LSB;
                    data_d  = beat_of(snap_q, row_q, last_col_q, 1'b0);
                    last_d  = (row_q == last_row_q);
                end
            end
            S_LSB: begin
                if (xfer) begin
                    if (row_q == last_row_q) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_MSB;
                        last_d  = 1'b0;
                        data_d  = beat_of(snap_q, row_q + 1'b1, last_col_q, 1'b1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            snap_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            snap_q     <= snap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uo_data  = data_q;
    assign uo_valid = valid_q;
    assign uo_last  = last_q;
    assign uo_busy  = busy_q;
    assign uo_done  = done_q;

endmodule
